// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stage stall requests, EX branches and traps into stall/flush vectors.
// Optional build macro PIPE_CTRL_PERF_EN adds stall_cycles_o, a count of cycles with PC stalled.
module pipe_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter int unsigned PC_W         = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stallreq_if_i,
    input  logic            stallreq_id_i,
    input  logic            stallreq_ex_i,
    input  logic            stallreq_mem_i,
    input  logic            ex_branch_flag_i,
    input  logic            trap_req_i,
    input  logic [PC_W-1:0] trap_pc_i,
    output logic [5:0]      stalled_o,
    output logic [5:0]      flush_o,
    output logic            redirect_valid_o,
    output logic [PC_W-1:0] redirect_pc_o,
    output logic            trap_busy_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]     stall_cycles_o
`endif
);

    typedef enum logic [1:0] {
        StRun   = 2'b00,
        StDrain = 2'b01,
        StFlush = 2'b10
    } state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic [3:0]      r_drain_cnt;
    logic [3:0]      w_drain_cnt_next;
    logic [3:0]      w_drain_cnt_dec;
    logic [PC_W-1:0] r_trap_pc;
    logic [PC_W-1:0] w_trap_pc_next;
    logic            r_redirect_valid;
    logic [PC_W-1:0] r_redirect_pc;
    logic [5:0]      w_stall_vec;
    logic [5:0]      w_stalled;
    logic [5:0]      w_flush;

    // Highest-priority stalling stage also stops every stage upstream of it.
    always_comb begin
        w_stall_vec = 6'b000000;
        if (stallreq_mem_i) begin
            w_stall_vec = 6'b011111;
        end else if (stallreq_ex_i) begin
            w_stall_vec = 6'b001111;
        end else if (stallreq_id_i) begin
            w_stall_vec = 6'b000111;
        end else if (stallreq_if_i) begin
            w_stall_vec = 6'b000011;
        end
    end

    assign w_drain_cnt_dec = (r_drain_cnt != 4'd0) ? (r_drain_cnt - 4'd1) : 4'd0;

    always_comb begin
        w_state_next     = r_state;
        w_drain_cnt_next = r_drain_cnt;
        w_trap_pc_next   = r_trap_pc;
        w_stalled        = 6'b000000;
        w_flush          = 6'b000000;
        case (r_state)
            StRun: begin
                if (trap_req_i) begin
                    w_state_next     = StDrain;
                    w_drain_cnt_next = 4'(DRAIN_CYCLES);
                    w_trap_pc_next   = trap_pc_i;
                    w_stalled        = 6'b000011;
                end else if (ex_branch_flag_i && !stallreq_ex_i && !stallreq_mem_i) begin
                    w_flush = 6'b000110;
                end else begin
                    w_stalled = w_stall_vec;
                end
            end
            StDrain: begin
                w_stalled        = stallreq_mem_i ? 6'b011111 : 6'b000111;
                w_drain_cnt_next = w_drain_cnt_dec;
                // Leave on the cycle the count hits zero: DRAIN lasts DRAIN_CYCLES when mem is idle.
                if ((w_drain_cnt_dec == 4'd0) && !stallreq_mem_i) begin
                    w_state_next = StFlush;
                end
            end
            StFlush: begin
                w_flush      = 6'b111111;
                w_state_next = StRun;
            end
            default: begin
                w_state_next = StRun;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state          <= StRun;
            r_drain_cnt      <= 4'd0;
            r_trap_pc        <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_state          <= w_state_next;
            r_drain_cnt      <= w_drain_cnt_next;
            r_trap_pc        <= w_trap_pc_next;
            r_redirect_valid <= (r_state == StFlush);
            if (r_state == StFlush) begin
                r_redirect_pc <= r_trap_pc;
            end
        end
    end

    // Vectors are forced low while reset is held, independent of the inputs.
    assign stalled_o        = rst ? w_stalled : 6'b000000;
    assign flush_o          = rst ? w_flush : 6'b000000;
    assign redirect_valid_o = r_redirect_valid;
    assign redirect_pc_o    = r_redirect_pc;
    assign trap_busy_o      = (r_state != StRun);

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cycles <= 32'd0;
        end else if (w_stalled[0]) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles_o = r_stall_cycles;
`endif

endmodule
